fp_add_pipe: RTL and testbench
==============================

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa field width; word width W = 1+EXP_W+MAN_W (default 16, fp16).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-style {sign, exp, man}.
REQ-008 SHALL have port b  input  W  operand B.
REQ-009 SHALL have port op_sub  input  1  1: compute a-b (B sign inverted); 0: a+b.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port result  output  W  sum/difference.
REQ-013 SHALL have port flags  output  3  {invalid, overflow, underflow} for the result.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/compare/align, S2 signed mantissa add, S3 normalise/round/pack; latency exactly 3 cycles from accepted input to out_valid absent stalls.
REQ-015 SHALL advance all stages together when adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational).
REQ-016 SHALL accept an operand pair on in_valid && in_ready; a stage with no accepted data SHALL carry valid=0 (bubble).
REQ-017 SHALL hold result, flags, out_valid stable while out_valid && !out_ready; no result lost, duplicated or reordered.
REQ-018 SHALL sustain one result per cycle with in_valid and out_ready held high.
REQ-019 SHALL align the smaller-magnitude operand by right shift of exponent difference with guard, round and sticky bits; shifts >= MAN_W+3 collapse to sticky only.
REQ-020 SHALL treat exp==0 inputs as zero (subnormals flushed, sign kept).
REQ-021 SHALL return +0 for exact cancellation of nonzero operands; -0 only when both effective operands are -0.
REQ-022 SHALL produce +/-Inf (exp all ones, man 0) and set overflow when the rounded exponent reaches all ones.
REQ-023 SHALL flush results with biased exponent < 1 to signed zero and set underflow.
REQ-024 SHALL output canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0) for any NaN input or Inf + (-Inf) effective; invalid set only for Inf-Inf or signalling-free rule: invalid set for Inf-Inf and any NaN input.
REQ-025 SHALL pass Inf through when one operand is Inf and the other finite, flags 0.
REQ-026 SHALL deassert all flags for exact or in-range results.

Reset
REQ-027 SHALL, on rst high, asynchronously clear all stage valid bits; out_valid=0, result=0, flags=0, in_ready=1 while rst high.
REQ-028 SHALL discard in-flight operations on reset mid-operation; first result after reset release comes only from operands accepted after release.

Configuration
REQ-029 SHALL honour macro FP_ADD_PIPE_RNE_EN: defined -> round-to-nearest, ties-to-even, using guard/round/sticky; undefined -> truncate toward zero, guard/round/sticky ignored, no rounding adder generated.
REQ-030 SHALL keep latency and handshake identical in both configurations.

Verification (defaults EXP_W=5, MAN_W=10)
REQ-031 SHALL cover a=0x3E00 (1.5), b=0x4100 (2.5), op_sub=0 -> result 0x4400 (4.0), flags 0, out_valid exactly 3 cycles after acceptance.
REQ-032 SHALL cover a=0x4580 (5.5), b=0x4100, op_sub=1 -> 0x4200 (3.0); a=0xBE00, b=0x3E00, op_sub=0 -> 0x0000.
REQ-033 SHALL cover a=0x7BFF, b=0x7BFF -> 0x7C00, flags=3'b010; a=0x7C00, b=0xFC00 -> 0x7E00, flags=3'b100.
REQ-034 SHALL cover rounding: a=0x3C01, b=0x1000 -> 0x3C02 with FP_ADD_PIPE_RNE_EN, 0x3C01 without; a=0x3C00, b=0x1000 -> 0x3C00 both.
REQ-035 SHALL cover backpressure: 6 back-to-back inputs, out_ready low cycles 4-8 -> in_ready low once pipeline full, all 6 results emitted in order, none duplicated.
REQ-036 SHALL cover rst asserted with 2 operations in flight -> out_valid 0 immediately, no stale result after release.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage floating-point add/sub with valid/ready handshake.
// Optional macro FP_ADD_PIPE_RNE_EN selects round-to-nearest-even (default: truncate).
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  input  logic                       op_sub,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic [2:0]                 flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int XW = EXP_W + $clog2(SW + 1) + 2;

  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [XW-1:0] SH_MAX = XW'(SW - 1);
  localparam logic signed [XW-1:0] E_ONE = XW'(1);
  localparam logic signed [XW-1:0] E_MAX =
    $signed({{(XW-EXP_W){1'b0}}, EONES});

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [2:0]       spec_flg;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sig_l;
    logic [SW-1:0]    sig_s;
    logic             neg_zero;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [2:0]       spec_flg;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic             neg_zero;
  } s2_t;

  logic adv;
  logic v1, v2;
  s1_t  s1_d, s1;
  s2_t  s2_d, s2;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: unpack / compare / align
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             sa, sb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic             b_big;
  logic [SW-1:0]    sig_a, sig_b, sig_s, sig_sh;
  logic [XW-1:0]    d;
  logic             nan_c, ainf_c, binf_c, norm_c;

  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ op_sub;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EONES) && (fa == '0);
  assign b_inf  = (eb == EONES) && (fb == '0);
  assign a_nan  = (ea == EONES) && (fa != '0);
  assign b_nan  = (eb == EONES) && (fb != '0);
  assign b_big  = b[W-2:0] > a[W-2:0];
  assign sig_a  = a_zero ? '0 : {1'b1, fa, 3'b000};
  assign sig_b  = b_zero ? '0 : {1'b1, fb, 3'b000};
  assign sig_s  = b_big ? sig_a : sig_b;
  assign d      = b_big ? {{(XW-EXP_W){1'b0}}, eb - ea}
                        : {{(XW-EXP_W){1'b0}}, ea - eb};

  assign nan_c  = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
  assign ainf_c = !nan_c && a_inf;
  assign binf_c = !nan_c && !a_inf && b_inf;
  assign norm_c = !(nan_c || ainf_c || binf_c);

  // right-shift the smaller significand, folding lost bits into sticky
  always_comb begin
    logic lost;
    lost   = 1'b0;
    sig_sh = '0;
    if (d >= SH_MAX) begin
      sig_sh = {{(SW-1){1'b0}}, |sig_s};
    end else begin
      sig_sh = sig_s >> d;
      for (int i = 0; i < SW; i++)
        if (XW'(i) < d) lost = lost | sig_s[i];
      sig_sh[0] = sig_sh[0] | lost;
    end
  end

  // assemble the S1 bundle and classify special operands
  always_comb begin
    s1_d          = '0;
    s1_d.sub      = sa ^ sb;
    s1_d.sign     = b_big ? sb : sa;
    s1_d.exp      = b_big ? eb : ea;
    s1_d.sig_l    = b_big ? sig_b : sig_a;
    s1_d.sig_s    = sig_sh;
    s1_d.neg_zero = a_zero && b_zero && sa && sb;
    unique case (1'b1)
      nan_c: begin
        s1_d.spec     = 1'b1;
        s1_d.spec_res = QNAN;
        s1_d.spec_flg = 3'b100;
      end
      ainf_c: begin
        s1_d.spec     = 1'b1;
        s1_d.spec_res = {sa, EONES, {MAN_W{1'b0}}};
      end
      binf_c: begin
        s1_d.spec     = 1'b1;
        s1_d.spec_res = {sb, EONES, {MAN_W{1'b0}}};
      end
      norm_c: s1_d.spec = 1'b0;
    endcase
  end

  // S1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) s1 <= s1_d;
    end
  end

  // ---------------- S2: signed magnitude add
  // S2 next-state bundle: magnitude sum or difference (sig_l >= sig_s)
  always_comb begin
    s2_d          = '0;
    s2_d.spec     = s1.spec;
    s2_d.spec_res = s1.spec_res;
    s2_d.spec_flg = s1.spec_flg;
    s2_d.sign     = s1.sign;
    s2_d.exp      = s1.exp;
    s2_d.neg_zero = s1.neg_zero;
    if (s1.sub)
      s2_d.sum = {1'b0, s1.sig_l} - {1'b0, s1.sig_s};
    else
      s2_d.sum = {1'b0, s1.sig_l} + {1'b0, s1.sig_s};
  end

  // S2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      s2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) s2 <= s2_d;
    end
  end

  // ---------------- S3: normalise / round / pack
  logic [XW-1:0]        pos, sh;
  logic [SW-1:0]        nrm;
  logic signed [XW-1:0] e_n, e_r;
  logic [MAN_W:0]       mant_sum;
  logic [W-1:0]         res_d;
  logic [2:0]           flg_d;
  logic                 unused;

  assign unused = ^{nrm[SW-1], nrm[2:0]};

  // find the leading one and normalise the sum
  always_comb begin
    pos = '0;
    for (int i = 0; i <= SW; i++)
      if (s2.sum[i]) pos = XW'(i);
    sh  = '0;
    nrm = '0;
    e_n = $signed({{(XW-EXP_W){1'b0}}, s2.exp});
    if (s2.sum[SW]) begin
      nrm    = s2.sum[SW:1];
      nrm[0] = s2.sum[1] | s2.sum[0];
      e_n    = e_n + E_ONE;
    end else begin
      sh  = SH_MAX - pos;
      nrm = s2.sum[SW-1:0] << sh;
      e_n = e_n - $signed(sh);
    end
  end

  // round the normalised significand
  always_comb begin
`ifdef FP_ADD_PIPE_RNE_EN
    logic inc;
    inc      = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    mant_sum = {1'b0, nrm[SW-2:3]} + {{MAN_W{1'b0}}, inc};
`else
    mant_sum = {1'b0, nrm[SW-2:3]};
`endif
    e_r = e_n + $signed({{(XW-1){1'b0}}, mant_sum[MAN_W]});
  end

  // pack result and flags, specials take priority
  always_comb begin
    res_d = '0;
    flg_d = '0;
    if (s2.spec) begin
      res_d = s2.spec_res;
      flg_d = s2.spec_flg;
    end else if (s2.sum == '0) begin
      res_d = {s2.neg_zero, {(W-1){1'b0}}};
    end else if (e_r >= E_MAX) begin
      res_d = {s2.sign, EONES, {MAN_W{1'b0}}};
      flg_d = 3'b010;
    end else if (e_r < E_ONE) begin
      res_d = {s2.sign, {(W-1){1'b0}}};
      flg_d = 3'b001;
    end else begin
      res_d = {s2.sign, e_r[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    end
  end

  // S3 output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        result <= res_d;
        flags  <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed table, handshake sequences and random
// traffic against an exact-integer reference model.
module tb_fp_add_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

`ifdef FP_ADD_PIPE_RNE_EN
  localparam bit RNE = 1'b1;
  localparam logic [15:0] RND_EXP = 16'h3C02;
`else
  localparam bit RNE = 1'b0;
  localparam logic [15:0] RND_EXP = 16'h3C01;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic [2:0]  flags;

  fp_add_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  flg;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  exp_t sbq[$];
  exp_t nxt;
  logic stalled = 1'b0;
  logic last_acc = 1'b0;
  logic saw_low = 1'b0;
  logic [15:0] held_res;
  logic [2:0]  held_flg;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: exact sum in units of 2^-24, then rounded.
  function automatic exp_t ref_add(logic [15:0] x, logic [15:0] y,
                                   logic sub);
    exp_t   r;
    logic   sx, sy, neg;
    int     ex, ey, fx, fy, p, e, sh;
    longint vx, vy, s, mag, q, rem, half;
    sx = x[15];
    sy = y[15] ^ sub;
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    fx = int'(x[9:0]);
    fy = int'(y[9:0]);
    r = '0;
    if ((ex == 31 && fx != 0) || (ey == 31 && fy != 0)) begin
      r.res = 16'h7E00; r.flg = 3'b100; return r;
    end
    if (ex == 31 && ey == 31) begin
      if (sx != sy) begin r.res = 16'h7E00; r.flg = 3'b100; end
      else r.res = {sx, 15'h7C00};
      return r;
    end
    if (ex == 31) begin r.res = {sx, 15'h7C00}; return r; end
    if (ey == 31) begin r.res = {sy, 15'h7C00}; return r; end
    vx = (ex == 0) ? 0 : (longint'(1024 + fx) << (ex - 1));
    vy = (ey == 0) ? 0 : (longint'(1024 + fy) << (ey - 1));
    if (sx) vx = -vx;
    if (sy) vy = -vy;
    if (vx == 0 && vy == 0) begin
      r.res = {sx & sy, 15'h0}; return r;
    end
    s = vx + vy;
    if (s == 0) return r;
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (p > 10) begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (RNE && (rem > half || (rem == half && q[0]))) q++;
    end else begin
      q = mag << (10 - p);
    end
    if (q == 2048) begin q = 1024; e++; end
    if (e >= 31) begin
      r.res = {neg, 15'h7C00}; r.flg = 3'b010;
    end else if (e < 1) begin
      r.res = {neg, 15'h0}; r.flg = 3'b001;
    end else begin
      r.res = {neg, e[4:0], q[9:0]};
    end
    return r;
  endfunction

  // one clock: check hold/handshake, score, advance to posedge+1
  task automatic cycle();
    exp_t e;
    #1;
    if (stalled) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(held_res));
      chk("hold_flags", 32'(flags), 32'(held_flg));
    end
    chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (!in_ready) saw_low = 1'b1;
    last_acc = in_valid && in_ready;
    if (last_acc) sbq.push_back(nxt);
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", result);
      end else begin
        e = sbq.pop_front();
        pops++;
        chk("result", 32'(result), 32'(e.res));
        chk("flags", 32'(flags), 32'(e.flg));
      end
    end
    stalled  = out_valid && !out_ready;
    held_res = result;
    held_flg = flags;
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [15:0] x, logic [15:0] y, logic s, exp_t e);
    int n;
    a = x; b = y; op_sub = s; nxt = e; in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(int budget);
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sbq.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_empty", 32'(sbq.size()), 32'd0);
  endtask

  task automatic gen_ops(output logic [15:0] x, output logic [15:0] y,
                         output logic s);
    int m;
    x = 16'($urandom);
    s = 1'($urandom);
    m = int'($urandom_range(0, 2));
    if (m == 0) y = 16'($urandom);
    else if (m == 1)
      y = {1'($urandom), 5'(x[14:10] + 5'($urandom_range(0, 4)) - 5'd2),
           10'($urandom)};
    else y = {1'($urandom), x[14:0]};
  endtask

  vec_t vt[$];

  initial begin
    exp_t        e;
    logic [15:0] x, y;
    logic        s;
    int          lat, acc, c, p0;
    logic        need;

    vt.push_back(vec_t'{16'h3E00, 16'h4100, 1'b0, 16'h4400, 3'b000});
    vt.push_back(vec_t'{16'h4580, 16'h4100, 1'b1, 16'h4200, 3'b000});
    vt.push_back(vec_t'{16'hBE00, 16'h3E00, 1'b0, 16'h0000, 3'b000});
    vt.push_back(vec_t'{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b010});
    vt.push_back(vec_t'{16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 3'b100});
    vt.push_back(vec_t'{16'h3C01, 16'h1000, 1'b0, RND_EXP,  3'b000});
    vt.push_back(vec_t'{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b000});
    vt.push_back(vec_t'{16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 3'b100});
    vt.push_back(vec_t'{16'hFE01, 16'h7C00, 1'b1, 16'h7E00, 3'b100});
    vt.push_back(vec_t'{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000});
    vt.push_back(vec_t'{16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000});
    vt.push_back(vec_t'{16'h7C00, 16'h7C00, 1'b0, 16'h7C00, 3'b000});
    vt.push_back(vec_t'{16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000});
    vt.push_back(vec_t'{16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b000});
    vt.push_back(vec_t'{16'h0000, 16'h8000, 1'b0, 16'h0000, 3'b000});
    vt.push_back(vec_t'{16'h0001, 16'h8000, 1'b0, 16'h0000, 3'b000});
    vt.push_back(vec_t'{16'h0400, 16'h0401, 1'b1, 16'h8000, 3'b001});
    vt.push_back(vec_t'{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000});
    vt.push_back(vec_t'{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 3'b000});
    vt.push_back(vec_t'{16'hC000, 16'h0200, 1'b0, 16'hC000, 3'b000});

    // reset state
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // latency of a single op
    e.res = 16'h4400; e.flg = 3'b000;
    send(16'h3E00, 16'h4100, 1'b0, e);
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    drain(20);

    // directed table, streamed back-to-back
    for (int i = 0; i < vt.size(); i++) begin
      e.res = vt[i].res;
      e.flg = vt[i].flg;
      send(vt[i].a, vt[i].b, vt[i].sub, e);
    end
    drain(20);

    // backpressure: 6 inputs, out_ready low in cycles 4-8
    p0 = pops; acc = 0; c = 0; saw_low = 1'b0; need = 1'b1;
    while ((acc < 6 || sbq.size() > 0) && c < 60) begin
      c++;
      out_ready = !(c >= 4 && c <= 8);
      if (acc < 6) begin
        if (need) begin
          gen_ops(x, y, s);
          a = x; b = y; op_sub = s; nxt = ref_add(x, y, s);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      need = last_acc;
      if (last_acc) acc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_in_ready_low", 32'(saw_low), 32'd1);
    chk("bp_accepted", 32'(acc), 32'd6);
    chk("bp_emitted", 32'(pops - p0), 32'd6);
    chk("bp_drained", 32'(sbq.size()), 32'd0);

    // reset with two operations in flight
    e = ref_add(16'h3C00, 16'h4000, 1'b0);
    send(16'h3C00, 16'h4000, 1'b0, e);
    e = ref_add(16'h4200, 16'h3C00, 1'b1);
    send(16'h4200, 16'h3C00, 1'b1, e);
    out_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    stalled = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    e = ref_add(16'h4500, 16'h3C00, 1'b0);
    send(16'h4500, 16'h3C00, 1'b0, e);
    drain(20);

    // random traffic with random backpressure
    need = 1'b1;
    for (int i = 0; i < 800; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (need) begin
        if ($urandom_range(0, 3) != 0) begin
          gen_ops(x, y, s);
          a = x; b = y; op_sub = s; nxt = ref_add(x, y, s);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      cycle();
      need = last_acc || !in_valid;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
